cordic_seq_ctrl: RTL and testbench
==================================

Name: cordic_seq_ctrl

Overview:
- Sequencer between the Nios II multicycle custom-instruction port and the iterative CORDIC cosine engine.
- Captures a float32 angle and converts it to unsigned fixed point by instantiating the existing float-to-fixed unpacker.
- Launches the engine, waits for its result with a timeout, then normalises and repacks the fixed-point cosine to float32 over several cycles.
- Presents the result with a one-cycle done pulse.

Parameters:
- FRACTIONAL_BITS, 30, fractional bits of the fixed-point format passed to the unpacker and the engine.
- TIMEOUT, 64, maximum WAIT cycles (with clk_en high) before the operation is aborted.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- clk_en  in  1  custom-instruction clock enable; when low, every register holds.
- start  in  1  request strobe; sampled only in IDLE.
- dataa  in  32  float32 angle, non-negative, magnitude < 2.
- result  out  32  float32 cosine; valid while done=1, held afterwards.
- done  out  1  registered, high for exactly one cycle per operation.
- busy  out  1  state != IDLE (combinational).
- eng_start  out  1  engine launch, combinational = (state==LAUNCH) && clk_en.
- eng_angle  out  32  registered unpacked angle, stable from LAUNCH until the next capture.
- eng_done  in  1  engine completion pulse; honoured only in WAIT.
- eng_result  in  32  engine cosine, unsigned fixed point with FRACTIONAL_BITS fraction bits; sampled with eng_done.

Behaviour:
- Reset: state=IDLE, done=0, result=0, eng_angle=0, timeout counter=0, shift count k=0. Reset asserted in any state returns the block to IDLE at that edge; no done pulse is emitted for the aborted operation.
- clk_en=0 freezes the FSM and all registers, and forces eng_start=0.
- States: IDLE, UNPACK, LAUNCH, WAIT, NORM, PACK. Every transition requires clk_en=1.
- IDLE: start=1 -> capture dataa into d_reg, go to UNPACK. start in any other state is ignored.
- UNPACK: eng_angle <= unpacker(d_reg) with SIGNED=0 (dataa=0 gives 0). Go to LAUNCH.
- LAUNCH: eng_start=1 for this single cycle; clear the timeout counter; go to WAIT.
- WAIT, eng_done=1: fx <= eng_result, k <= 0.
  - fx==0 goes to PACK with the zero flag set.
  - Otherwise go to NORM.
- WAIT, timeout: the counter increments each cycle. If it reaches TIMEOUT-1 with eng_done=0, go to PACK with the NaN flag set.
- WAIT, simultaneous events: eng_done=1 in the timeout cycle wins and completes normally.
- NORM: one decision per cycle.
  - fx[31]=1 -> go to PACK.
  - Otherwise fx <= fx<<1 and k <= k+1.
  - At most 31 shifts for nonzero fx.
- PACK computes the result by flag:
  - Normal: {1'b0, exp[7:0], fx[30:8]}, with exp = 127 + 31 - FRACTIONAL_BITS - k; mantissa bits are truncated, not rounded.
  - Zero flag: 32'h00000000.
  - NaN flag: 32'h7FC00000.
- PACK registers result, sets done=1 for the next cycle only, and goes to IDLE.
- start may be accepted in the IDLE cycle where done=1 (back-to-back operations allowed).
- Latency, start-capture edge to done high: 4 + W + (k+1), where W = WAIT cycles including the eng_done cycle. For fx=0 the (k+1) term is 0.
- eng_done outside WAIT is ignored; stale eng_done pulses are never latched.
- Sign bit of result is always 0.

Test Plan:
- Basic: dataa=32'h3F000000 -> eng_angle=32'h20000000; engine returns 32'h38000000 after 5 cycles -> k=2, result=32'h3F600000, done high exactly one cycle.
- Zero input: dataa=0 -> eng_angle=0; engine returns 32'h40000000 -> result=32'h3F800000.
- Timeout: engine never pulses eng_done, TIMEOUT=64 -> done after 64 WAIT cycles, result=32'h7FC00000. Also: eng_done in cycle 63 -> normal result.
- Zero result: engine returns 0 -> PACK without NORM, result=32'h00000000.
- Protocol: start pulsed during WAIT is ignored.
  - clk_en low for 10 cycles mid-WAIT and mid-NORM -> no state or eng_start change, result unaffected.
  - Back-to-back start in the done cycle is accepted.
- Reset mid-operation: reset in NORM -> next cycle IDLE, done=0, result=0, busy=0. A subsequent operation completes correctly.

Source files
------------

// File: rtl/cordic_seq_ctrl.sv
// cordic_seq_ctrl: sequences float32 angle unpack, CORDIC engine launch/wait and float32 repack of the cosine.
module float_to_fixed_unpacker #(
  parameter int FRACTIONAL_BITS = 30,
  parameter int SIGNED = 0
) (
  input  logic [31:0] f,
  output logic [31:0] x
);
  localparam int OFS = FRACTIONAL_BITS - 150;
  logic signed [31:0] sh;
  logic [31:0] m, mag;
  always_comb begin
    sh = $signed({24'd0, f[30:23]}) + OFS;
    m = {8'd0, 1'b1, f[22:0]};
    mag = (f[30:23] == 8'd0) ? 32'd0 : (sh >= 0) ? m << sh : m >> (-sh);
    x = ((SIGNED != 0) && f[31]) ? -mag : mag;
  end
endmodule

module cordic_seq_ctrl #(
  parameter int FRACTIONAL_BITS = 30,
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        start,
  input  logic [31:0] dataa,
  output logic [31:0] result,
  output logic        done,
  output logic        busy,
  output logic        eng_start,
  output logic [31:0] eng_angle,
  input  logic        eng_done,
  input  logic [31:0] eng_result
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [7:0] EB = 8'(127 + 31 - FRACTIONAL_BITS);
  typedef enum logic [2:0] {IDLE, UNPACK, LAUNCH, WAIT, NORM, PACK} state_t;
  state_t state, nxt;
  logic [31:0] d_reg, fx, unp;
  logic [4:0] k;
  logic [CW-1:0] cnt;
  logic zf, nf, tmo;
  float_to_fixed_unpacker #(.FRACTIONAL_BITS(FRACTIONAL_BITS), .SIGNED(0)) u_unp (.f(d_reg), .x(unp));
  assign busy = state != IDLE;
  assign eng_start = (state == LAUNCH) && clk_en;
  assign tmo = cnt == CW'(TIMEOUT - 1);
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start ? UNPACK : IDLE;
      UNPACK:  nxt = LAUNCH;
      LAUNCH:  nxt = WAIT;
      WAIT:    nxt = eng_done ? ((eng_result == 32'd0) ? PACK : NORM) : (tmo ? PACK : WAIT);
      NORM:    nxt = fx[31] ? PACK : NORM;
      PACK:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      done <= 1'b0;
      result <= '0;
      eng_angle <= '0;
      d_reg <= '0;
      fx <= '0;
      k <= '0;
      cnt <= '0;
      zf <= 1'b0;
      nf <= 1'b0;
    end else if (clk_en) begin
      state <= nxt;
      done <= state == PACK;
      case (state)
        IDLE:   if (start) d_reg <= dataa;
        UNPACK: eng_angle <= unp;
        LAUNCH: cnt <= '0;
        WAIT: begin
          cnt <= cnt + 1'b1;
          if (eng_done) begin
            fx <= eng_result;
            k <= '0;
            zf <= eng_result == 32'd0;
            nf <= 1'b0;
          end else if (tmo) begin
            zf <= 1'b0;
            nf <= 1'b1;
          end
        end
        NORM: if (!fx[31]) begin
          fx <= fx << 1;
          k <= k + 1'b1;
        end
        PACK:   result <= nf ? 32'h7FC00000 : zf ? 32'h0 : {1'b0, EB - {3'd0, k}, fx[30:8]};
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_cordic_seq_ctrl.sv
// tb_cordic_seq_ctrl: directed vectors with a reactive engine stub and hand-computed results/latencies.
module tb_cordic_seq_ctrl;
  logic clk, reset, clk_en, start, done, busy, eng_start, eng_done;
  logic [31:0] dataa, result, eng_angle, eng_result;
  int n_chk = 0, n_fail = 0, cyc = 0;

  cordic_seq_ctrl #(.FRACTIONAL_BITS(30), .TIMEOUT(64)) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .start(start), .dataa(dataa),
    .result(result), .done(done), .busy(busy), .eng_start(eng_start),
    .eng_angle(eng_angle), .eng_done(eng_done), .eng_result(eng_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, want);
    end
  endtask

  // mode 1: stall 10 cycles in WAIT and pulse a stray start; mode 2: stall 10 cycles in NORM
  task automatic op(input string tag, input logic [31:0] a, input int w, input logic [31:0] er,
                    input int mode, input bit pre, input bit chain, input logic [31:0] na,
                    input logic [31:0] xang, input logic [31:0] xres, input int xlat);
    int t, c0;
    if (!pre) begin
      @(negedge clk);
      dataa = a;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    c0 = cyc;
    t = 0;
    while (!eng_start && t < 10) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_launch"}, eng_start, 1);
    check({tag, "_angle"}, eng_angle, xang);
    if (mode == 1) begin
      clk_en = 1'b0;
      #1;
      check({tag, "_estart_gated"}, eng_start, 0);
      clk_en = 1'b1;
    end
    @(negedge clk);
    if (mode == 1) begin
      clk_en = 1'b0;
      repeat (10) @(negedge clk);
      check({tag, "_stall_busy"}, busy, 1);
      check({tag, "_stall_estart"}, eng_start, 0);
      clk_en = 1'b1;
      start = 1'b1;
      dataa = 32'h3F000000;
      @(negedge clk);
      start = 1'b0;
      repeat (w - 2) @(negedge clk);
    end else if (w > 0) repeat (w - 1) @(negedge clk);
    if (w > 0) begin
      eng_result = er;
      eng_done = 1'b1;
      @(negedge clk);
      eng_done = 1'b0;
    end
    if (mode == 2) begin
      clk_en = 1'b0;
      repeat (10) @(negedge clk);
      check({tag, "_stall_busy"}, busy, 1);
      check({tag, "_stall_done"}, done, 0);
      clk_en = 1'b1;
    end
    t = 0;
    while (!done && t < 200) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_done"}, done, 1);
    check({tag, "_latency"}, 32'(cyc - c0 + 1), 32'(xlat));
    check({tag, "_result"}, result, xres);
    if (chain) begin
      dataa = na;
      start = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_result_hold"}, result, xres);
    check({tag, "_busy_after"}, busy, chain);
  endtask

  initial begin
    int t;
    reset = 1'b1;
    clk_en = 1'b1;
    start = 1'b0;
    dataa = '0;
    eng_done = 1'b0;
    eng_result = '0;
    repeat (3) @(negedge clk);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_busy", busy, 0);
    check("rst_angle", eng_angle, 0);
    check("rst_estart", eng_start, 0);
    reset = 1'b0;

    op("basic", 32'h3F000000, 5, 32'h38000000, 0, 0, 0, 0, 32'h20000000, 32'h3F600000, 12);
    op("zero_in", 32'h00000000, 3, 32'h40000000, 0, 0, 0, 0, 32'h00000000, 32'h3F800000, 9);
    op("zero_res", 32'h3F800000, 2, 32'h00000000, 0, 0, 0, 0, 32'h40000000, 32'h00000000, 6);
    op("timeout", 32'h3F000000, 0, 32'h0, 0, 0, 0, 0, 32'h20000000, 32'h7FC00000, 68);
    op("tmo_edge", 32'h3F000000, 64, 32'h40000000, 0, 0, 0, 0, 32'h20000000, 32'h3F800000, 70);
    op("stall_wait", 32'h3FC00000, 4, 32'h20000000, 1, 0, 0, 0, 32'h60000000, 32'h3F000000, 21);
    op("stall_norm", 32'h3E800000, 3, 32'h01000000, 2, 0, 0, 0, 32'h10000000, 32'h3C800000, 25);
    op("b2b_a", 32'h3F000000, 2, 32'h38000000, 0, 0, 1, 32'h3F400000, 32'h20000000, 32'h3F600000, 9);
    op("b2b_b", 32'h3F400000, 6, 32'h30000000, 0, 1, 0, 0, 32'h30000000, 32'h3F400000, 13);

    @(negedge clk);
    dataa = 32'h3F800000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t = 0;
    while (!eng_start && t < 10) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    eng_result = 32'h00000001;
    eng_done = 1'b1;
    @(negedge clk);
    eng_done = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_done", done, 0);
    check("midrst_result", result, 0);
    check("midrst_busy", busy, 0);
    op("post_rst", 32'h3F800000, 2, 32'h00000001, 0, 0, 0, 0, 32'h40000000, 32'h30800000, 38);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
